dffram_1rw1r: RTL



---
 rtl/dffram_pkg.sv | 21 ++
 rtl/dffram_clear_ctrl.sv | 50 +++++
 rtl/dffram_1rw1r.sv | 84 ++++++++
 3 files changed

// File: rtl/dffram_pkg.sv
// Shared types and helpers for the 1RW/1R DFF RAM.
// Holds the byte width, the clear-FSM state type and the byte-merge helper.
package dffram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    // Selects the new byte where its write enable is set, else keeps the old one.
    function automatic logic [BYTE_W-1:0] merge_byte(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              we
    );
        return we ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dffram_clear_ctrl.sv
// Post-reset clear engine: walks every word address once, writing zero.
// Ports: CLK, RST (async, active-high), BUSY, clear_we, clear_addr.
module dffram_clear_ctrl
    import dffram_pkg::*;
#(
    parameter int A_WIDTH      = 9,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               BUSY,
    output logic               clear_we,
    output logic [A_WIDTH-1:0] clear_addr
);

    clr_state_t         state, state_nx;
    logic [A_WIDTH-1:0] cnt, cnt_nx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CLR_ON_RESET ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clear_we = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                // Counter wraps back to zero on the last word.
                cnt_nx   = cnt + 1'b1;
                if (cnt == '1)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign clear_addr = cnt;
    assign BUSY       = (state == CLEAR);

endmodule

// File: rtl/dffram_1rw1r.sv
// Parametrised DFF RAM with one byte-writable RW port and one read port.
// Ports: CLK, RST, BUSY, EN0/WE0/A0/Di0/Do0 (RW), EN1/A1/Do1 (R).
// Optional macro DFFRAM_BYPASS_EN forwards port-0 write data to port 1
// on a same-address collision; otherwise port 1 is read-first.
module dffram_1rw1r
    import dffram_pkg::*;
#(
    parameter int WSIZE        = 4,
    parameter int A_WIDTH      = 9,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  BUSY,
    input  logic                  EN0,
    input  logic [WSIZE-1:0]      WE0,
    input  logic [A_WIDTH-1:0]    A0,
    input  logic [BYTE_W*WSIZE-1:0] Di0,
    output logic [BYTE_W*WSIZE-1:0] Do0,
    input  logic                  EN1,
    input  logic [A_WIDTH-1:0]    A1,
    output logic [BYTE_W*WSIZE-1:0] Do1
);

    localparam int NUM_WORDS = 2**A_WIDTH;
    localparam int DW        = BYTE_W * WSIZE;

    logic [DW-1:0]      mem [NUM_WORDS];
    logic               clear_we;
    logic [A_WIDTH-1:0] clear_addr;
    logic [DW-1:0]      old0, old1, wr_word, rd1;
    logic               wr0;

    dffram_clear_ctrl #(
        .A_WIDTH      (A_WIDTH),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr (
        .CLK        (CLK),
        .RST        (RST),
        .BUSY       (BUSY),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign old0 = mem[A0];
    assign old1 = mem[A1];

    always_comb begin
        wr_word = old0;
        for (int i = 0; i < WSIZE; i++)
            wr_word[i*BYTE_W +: BYTE_W] = merge_byte(
                old0[i*BYTE_W +: BYTE_W], Di0[i*BYTE_W +: BYTE_W], WE0[i]);
    end

    assign wr0 = !BUSY && EN0 && (|WE0);

    // The array has no reset; the clear engine owns it while BUSY.
    always_ff @(posedge CLK) begin
        if (clear_we)
            mem[clear_addr] <= '0;
        else if (wr0)
            mem[A0] <= wr_word;
    end

`ifdef DFFRAM_BYPASS_EN
    assign rd1 = (wr0 && EN1 && (A1 == A0)) ? wr_word : old1;
`else
    assign rd1 = old1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Do0 <= '0;
            Do1 <= '0;
        end else if (BUSY) begin
            Do0 <= '0;
            Do1 <= '0;
        end else begin
            Do0 <= EN0 ? old0 : '0;
            Do1 <= EN1 ? rd1 : '0;
        end
    end

endmodule
